iter_shift_unit: RTL
====================

Name: iter_shift_unit

Overview:
Multi-cycle parametrised shift unit for the RV32I execute stage. It implements SLL/SLLI, SRL/SRLI and SRA/SRAI on a valid/ready handshake. It generalises the single-cycle arithmetic-right-shift operation in three ways: all three shift modes, configurable operand width, and an iterative datapath that shifts at most STEP bits per cycle to cut shifter area and critical path. It sits beside the ALU and is selected by the execute-stage decode.

Parameters:
DATA_WIDTH, 32, operand/result width; power of two, >= 8
STEP, 4, max bits shifted per cycle; power of two, 1..DATA_WIDTH
SHAMT_W, $clog2(DATA_WIDTH), shift-amount width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept (high only in IDLE)
op  in  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 illegal
src_a  in  DATA_WIDTH  value to shift (rs1)
src_b  in  DATA_WIDTH  shift amount source (rs2 or sign-extended immediate)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  DATA_WIDTH  shifted value
op_err  out  1  qualified by out_valid; op was 11
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; in_ready=1; out_valid=0; result=0; op_err=0; busy=0; internal shamt/op regs=0.
- Shift amount = src_b[SHAMT_W-1:0]; upper bits ignored (RISC-V masking). Sampled only on accept.
- Accept = in_valid && in_ready. On accept: latch src_a into working reg, op, shamt.
- FSM:
  - IDLE: on accept with op==11 -> DONE, result=src_a, op_err=1. On accept with shamt==0 -> DONE, result=src_a. Otherwise -> SHIFT.
  - SHIFT: each cycle shift working reg by k=min(remaining, STEP). Remaining -= k. When the post-shift remaining==0 -> DONE. The working reg drives result.
  - DONE: out_valid=1. Hold result/op_err stable until out_ready. On out_valid && out_ready -> IDLE, out_valid=0 next cycle.
- Latency (accept edge to out_valid high) = max(1, ceil(shamt/STEP)) cycles. in_ready is low in SHIFT and DONE, so there is no same-cycle back-to-back accept. Minimum issue interval is latency+1.
- Fill rules:
  - SLL: zeros into LSBs.
  - SRL: zeros into MSBs.
  - SRA: copies of the latched original src_a[DATA_WIDTH-1] into MSBs for every step. Sign is stored at accept, never re-read from the working reg.
- shamt = DATA_WIDTH-1 is the maximum. SRA of a negative value gives all-ones; SRL of 0x8000_0000 gives 1.
- Inputs changing while busy are ignored.
- in_valid while busy: no effect. The requester must hold its request until in_ready.
- rst_n low mid-SHIFT or mid-DONE aborts immediately to the reset values. No result is emitted.
- Unknown op after accept cannot occur; op is registered.

Decomposition:
- Package shift_pkg: typedef enum logic[1:0] shift_op_t {SH_SLL, SH_SRL, SH_SRA, SH_ILL}; typedef enum state_t {S_IDLE, S_SHIFT, S_DONE}; op encoding constants.
- Sub-module shift_step: combinational, shifts by a variable k in 0..STEP with mode and fill-bit inputs. The parent instantiates it once.
- Parent holds FSM, counters and handshake only.

Test Plan:
1. DATA_WIDTH=32, STEP=4: SRA src_a=0xFFFFFFF8, src_b=2 -> result 0xFFFFFFFE, op_err=0, out_valid exactly 1 cycle after accept.
2. SRL src_a=0x80000000, src_b=31 -> result 0x00000001 after 8 cycles. Same operands with SRA -> 0xFFFFFFFF after 8 cycles. busy high throughout; in_ready low.
3. SLL src_a=0x00000001, src_b=0x00000022 (masked to 2) -> 0x00000004. src_b=0 -> 0x00000001 at latency 1.
4. Backpressure: SRA 0x00000010 by 2, hold out_ready=0 for 5 cycles -> result 0x00000004 and out_valid stable. in_ready rises the cycle after the out_ready handshake.
5. op=11, src_a=0x12345678 -> result 0x12345678, op_err=1, latency 1. A following legal op reports op_err=0.
6. Assert rst_n=0 asynchronously mid-SHIFT (SRL by 20) -> out_valid=0, in_ready=1, result=0 immediately. No spurious out_valid after release. Repeat with STEP=1 and STEP=32 (single-cycle) for the latency formula.

Source files
------------

// File: rtl/shift_pkg.sv
// ==== shift_pkg : shared types for the iterative shift unit -- rev 1.0 ====
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ILL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ==== shift_step : one bounded shift step (0..STEP bits) with fill -- rev 1.0 ====
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K_W        = 3
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [K_W-1:0]        k,
  input  shift_op_t             mode,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] fill_mask;

  // Right shifts place 'fill' in the k vacated MSBs; SLL always fills with zeros.
  always_comb begin
    fill_mask = ~({DATA_WIDTH{1'b1}} >> k) & {DATA_WIDTH{fill}};
    if (mode == SH_SLL) begin
      data_out = data << k;
    end else begin
      data_out = (data >> k) | fill_mask;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_shift_unit.sv
// ==== iter_shift_unit : multi-cycle SLL/SRL/SRA unit, STEP bits per cycle -- rev 1.0 ====
`default_nettype none

module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  STEP       = 4,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  op_err,
  output logic                  busy
);

  localparam int K_W = $clog2(STEP + 1);
  localparam int R_W = (K_W > SHAMT_W) ? K_W : SHAMT_W;

  state_t                state;
  logic [DATA_WIDTH-1:0] work;
  shift_op_t             op_r;
  logic [SHAMT_W-1:0]    remaining;
  logic                  sign_r;

  logic                  idle;
  logic [SHAMT_W-1:0]    rem_cur;
  shift_op_t             mode_cur;
  logic [DATA_WIDTH-1:0] data_cur;
  logic                  fill_cur;
  logic [R_W-1:0]        rem_ext;
  logic [K_W-1:0]        k;
  logic [SHAMT_W-1:0]    rem_next;
  logic [DATA_WIDTH-1:0] step_out;
  logic                  unused_src_b;

  assign idle         = (state == S_IDLE);
  assign unused_src_b = ^src_b[DATA_WIDTH-1:SHAMT_W];
  assign result       = work;

  // The first step runs in the accept cycle straight off the inputs, so a shift
  // of up to STEP bits is done in one cycle, the same as a zero shift.
  always_comb begin
    rem_cur  = idle ? src_b[SHAMT_W-1:0] : remaining;
    mode_cur = idle ? shift_op_t'(op) : op_r;
    data_cur = idle ? src_a : work;
    fill_cur = (mode_cur == SH_SRA) && (idle ? src_a[DATA_WIDTH-1] : sign_r);
    rem_ext  = R_W'(rem_cur);
    k        = (rem_ext >= R_W'(STEP)) ? K_W'(STEP) : K_W'(rem_ext);
    rem_next = SHAMT_W'(rem_ext - R_W'(k));
  end

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .K_W        (K_W)
  ) u_step (
    .data     (data_cur),
    .k        (k),
    .mode     (mode_cur),
    .fill     (fill_cur),
    .data_out (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      work      <= '0;
      op_r      <= SH_SLL;
      remaining <= '0;
      sign_r    <= 1'b0;
      op_err    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r      <= mode_cur;
            sign_r    <= src_a[DATA_WIDTH-1];
            remaining <= rem_next;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            if (mode_cur == SH_ILL) begin
              work      <= src_a;
              op_err    <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              work   <= step_out;
              op_err <= 1'b0;
              if (rem_next == '0) begin
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end
          end
        end
        S_SHIFT: begin
          work      <= step_out;
          remaining <= rem_next;
          if (rem_next == '0) begin
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
